// File: rtl/pdp8i_pkg.sv
// rtl/pdp8i_pkg.sv - shared PDP-8/I backplane types and constants
package pdp8i_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_PULSE   = 2'd1,
    CH_RECOVER = 2'd2
  } ch_state_e;

  localparam int M602_SHORT = 5;
  localparam int M602_LONG  = 11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/m602_if.sv
// rtl/m602_if.sv - m602 backplane pin bundle for both channels
interface m602_if;
  logic D2, E2, J2, F2, H2;
  logic M2, N2, S2, P2, R2;

  modport master (
    output D2, E2, J2, M2, N2, S2,
    input  F2, H2, P2, R2
  );

  modport slave (
    input  D2, E2, J2, M2, N2, S2,
    output F2, H2, P2, R2
  );
endinterface

// File: rtl/m602_channel.sv
// rtl/m602_channel.sv - one pulse amplifier channel: edge detect, width FSM, lockout
module m602_channel
  import pdp8i_pkg::*;
#(
  parameter int SHORT_WIDTH = M602_SHORT,
  parameter int LONG_WIDTH  = M602_LONG,
  parameter int RECOVERY    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  input  logic cond,
  input  logic sel_short,
  output logic pulse
);

  localparam int MAXV = max3(SHORT_WIDTH, LONG_WIDTH, RECOVERY);
  localparam int CW   = ($clog2(MAXV) < 1) ? 1 : $clog2(MAXV);
  localparam logic [CW-1:0] SHORT_LOAD = CW'(SHORT_WIDTH - 1);
  localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_WIDTH - 1);
  localparam logic [CW-1:0] REC_LOAD   = (RECOVERY > 0) ? CW'(RECOVERY - 1) : '0;

  generate
    if (SHORT_WIDTH < 1 || LONG_WIDTH < 1) begin : g_bad_width
      $error("m602_channel: pulse widths must be at least 1");
    end
  endgenerate

  ch_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;
  logic          armed_q;
  logic          fire;

  // armed_q blocks the first cycle after reset so a trigger held low through
  // reset release is not mistaken for a falling edge against prev=1.
  assign fire  = armed_q && prev_q && !trig && cond;
  assign pulse = (state_q == CH_PULSE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CH_IDLE: begin
        if (fire) begin
          state_d = CH_PULSE;
          cnt_d   = sel_short ? SHORT_LOAD : LONG_LOAD;
        end
      end
      CH_PULSE: begin
        if (cnt_q == '0) begin
          if (RECOVERY == 0) begin
            state_d = CH_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = CH_RECOVER;
            cnt_d   = REC_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CH_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = CH_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= trig;
      armed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/m602.sv
// rtl/m602.sv - two-channel PDP-8/I pulse amplifier with complement outputs
module m602
  import pdp8i_pkg::*;
#(
  parameter int SHORT_WIDTH = M602_SHORT,
  parameter int LONG_WIDTH  = M602_LONG,
  parameter int RECOVERY    = 4
) (
  input  logic   clk,
  input  logic   reset,
  m602_if.slave  pa
);

  logic ch1_pulse;
  logic ch2_pulse;

  m602_channel #(
    .SHORT_WIDTH (SHORT_WIDTH),
    .LONG_WIDTH  (LONG_WIDTH),
    .RECOVERY    (RECOVERY)
  ) u_ch1 (
    .clk       (clk),
    .reset     (reset),
    .trig      (pa.D2),
    .cond      (pa.E2),
    .sel_short (pa.J2),
    .pulse     (ch1_pulse)
  );

  m602_channel #(
    .SHORT_WIDTH (SHORT_WIDTH),
    .LONG_WIDTH  (LONG_WIDTH),
    .RECOVERY    (RECOVERY)
  ) u_ch2 (
    .clk       (clk),
    .reset     (reset),
    .trig      (pa.M2),
    .cond      (pa.N2),
    .sel_short (pa.S2),
    .pulse     (ch2_pulse)
  );

  // Complements are inversions of registered state, so still glitch-free.
  assign pa.F2 = ch1_pulse;
  assign pa.H2 = ~ch1_pulse;
  assign pa.P2 = ch2_pulse;
  assign pa.R2 = ~ch2_pulse;

endmodule

// File: tb/tb_m602.sv
// tb/tb_m602.sv - scoreboard bench for the m602 pulse amplifier
module tb_m602;

  typedef struct {
    int start;
    int width;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t q1[$];
  exp_t q2[$];

  m602_if pa ();

  m602 dut (
    .clk   (clk),
    .reset (reset),
    .pa    (pa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push1(input int start, input int width);
    exp_t e;
    e.start = start;
    e.width = width;
    q1.push_back(e);
  endtask

  task automatic push2(input int start, input int width);
    exp_t e;
    e.start = start;
    e.width = width;
    q2.push_back(e);
  endtask

  // Pulse monitor: measures each output pulse and retires it against the scoreboard.
  logic f_prev, p_prev;
  int   f_start, f_len, p_start, p_len;
  initial begin
    f_prev = 1'b0; p_prev = 1'b0;
    f_start = 0; f_len = 0; p_start = 0; p_len = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    check("h2_inv", int'(pa.H2), int'(!pa.F2));
    check("r2_inv", int'(pa.R2), int'(!pa.P2));
    if (pa.F2 && !f_prev) begin
      f_start = cyc;
      f_len   = 0;
    end
    if (pa.F2) f_len++;
    if (!pa.F2 && f_prev) begin
      if (q1.size() == 0) begin
        check("ch1_unexpected_pulse", f_start, -1);
      end else begin
        e = q1.pop_front();
        check("ch1_start", f_start, e.start);
        check("ch1_width", f_len, e.width);
      end
    end
    if (pa.P2 && !p_prev) begin
      p_start = cyc;
      p_len   = 0;
    end
    if (pa.P2) p_len++;
    if (!pa.P2 && p_prev) begin
      if (q2.size() == 0) begin
        check("ch2_unexpected_pulse", p_start, -1);
      end else begin
        e = q2.pop_front();
        check("ch2_start", p_start, e.start);
        check("ch2_width", p_len, e.width);
      end
    end
    f_prev = pa.F2;
    p_prev = pa.P2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    pa.D2 = 1'b1; pa.E2 = 1'b1; pa.J2 = 1'b1;
    pa.M2 = 1'b1; pa.N2 = 1'b1; pa.S2 = 1'b1;
    step(3);
    check("reset_f2", int'(pa.F2), 0);
    check("reset_h2", int'(pa.H2), 1);
    check("reset_p2", int'(pa.P2), 0);
    check("reset_r2", int'(pa.R2), 1);
    reset = 1'b0;
    step(2);

    // Short pulse.
    pa.J2 = 1'b1; pa.D2 = 1'b0; push1(cyc + 1, 5);
    step(1); pa.D2 = 1'b1;
    step(20);

    // Long pulse, width select toggled mid-pulse.
    pa.J2 = 1'b0; pa.D2 = 1'b0; push1(cyc + 1, 11);
    step(1); pa.D2 = 1'b1;
    step(3); pa.J2 = 1'b1;
    step(2); pa.J2 = 1'b0;
    step(20);

    // Conditioning low: no pulse.
    pa.J2 = 1'b1; pa.E2 = 1'b0; pa.D2 = 1'b0;
    step(1); pa.D2 = 1'b1; pa.E2 = 1'b1;
    step(10);

    // Retrigger inside pulse and inside recovery ignored; after recovery accepted.
    pa.D2 = 1'b0; s = cyc + 1; push1(s, 5);
    step(1); pa.D2 = 1'b1; pa.E2 = 1'b0;
    step(1); pa.E2 = 1'b1; pa.D2 = 1'b0;
    step(1); pa.D2 = 1'b1;
    goto(s + 6); pa.D2 = 1'b0;
    step(1); pa.D2 = 1'b1;
    goto(s + 9); pa.D2 = 1'b0; push1(s + 10, 5);
    step(1); pa.D2 = 1'b1;
    step(20);

    // Reset on pulse cycle 3 truncates the pulse.
    pa.D2 = 1'b0; s = cyc + 1; push1(s, 3);
    step(1); pa.D2 = 1'b1;
    goto(s + 2); reset = 1'b1;
    step(1);
    check("rst_mid_f2", int'(pa.F2), 0);
    check("rst_mid_h2", int'(pa.H2), 1);
    reset = 1'b0;
    step(3);
    pa.D2 = 1'b0; push1(cyc + 1, 5);
    step(1); pa.D2 = 1'b1;
    step(20);

    // Trigger coinciding with reset: reset wins.
    pa.D2 = 1'b0; reset = 1'b1;
    step(1); pa.D2 = 1'b1;
    step(1); reset = 1'b0;
    step(10);

    // Trigger held low through reset release: no pulse.
    pa.D2 = 1'b0; reset = 1'b1;
    step(2); reset = 1'b0;
    step(3); pa.D2 = 1'b1;
    step(10);

    // Both channels in the same cycle with different widths.
    pa.J2 = 1'b1; pa.S2 = 1'b0;
    pa.D2 = 1'b0; pa.M2 = 1'b0;
    push1(cyc + 1, 5); push2(cyc + 1, 11);
    step(1); pa.D2 = 1'b1; pa.M2 = 1'b1;
    step(30);

    check("ch1_sb_empty", q1.size(), 0);
    check("ch2_sb_empty", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
